uart_program_loader_tx: RTL and testbench

// - UART transmitter that streams a program image into the CPU's UART program loader over the io_rx line.
// - Accepts 32-bit words on a valid/ready stream and sends each as 4 bytes, least significant byte first, as 8N1 frames.
// - After the word marked last, appends SENTINEL so the loader raises run_flag.
// - Used as bench-side stimulus and as the on-board host bridge.

---
 rtl/uart_program_loader_tx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_program_loader_tx.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_program_loader_tx.sv
// Streams 32-bit program words LSB-first as 8N1 UART frames, then a sentinel word after the last (even parity with UART_LOADER_PARITY_EN).
// Latency: start bit 2 clks after accept; backpressure: s_ready low while hold is full or from last-accept until done.
module uart_program_loader_tx #(
  parameter int          CLKS_PER_BIT = 4,
  parameter logic [31:0] SENTINEL     = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic [15:0] words_sent
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

`ifdef UART_LOADER_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_NEXT} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_NEXT} state_t;
`endif

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         bit_idx_q;
  logic [1:0]         byte_idx_q;
  logic [31:0]        active_q;
  logic               act_last_q;
  logic               act_sent_q;
  logic [31:0]        hold_q;
  logic               hold_last_q;
  logic               hold_full_q;
  logic               lock_q;
  logic               s_ready_q;
  logic               tx_q;
  logic               done_q;
  logic [15:0]        words_q;

  logic               accept;
  logic               timer_done;
  logic               final_byte;
  logic               hold_pop;
  logic               hold_full_d;
  logic               lock_d;
  logic               tx_d;
  logic [7:0]         cur_byte;

  assign accept     = s_valid && s_ready_q;
  assign timer_done = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign final_byte = (byte_idx_q == 2'd3);
  assign cur_byte   = active_q[{byte_idx_q, 3'b000} +: 8];

  // Hold drains into active from IDLE, or at the end of a word unless the sentinel must follow.
  assign hold_pop = hold_full_q &&
                    ((state_q == ST_IDLE) || ((state_q == ST_NEXT) && final_byte && !act_last_q));

  always_comb begin
    hold_full_d = hold_full_q;
    if (accept) begin
      hold_full_d = 1'b1;
    end else if (hold_pop) begin
      hold_full_d = 1'b0;
    end
  end

  // Lockout spans from the last-word accept through the done cycle.
  always_comb begin
    lock_d = lock_q;
    if (accept && s_last) begin
      lock_d = 1'b1;
    end else if (done_q) begin
      lock_d = 1'b0;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = cur_byte[bit_idx_q];
`ifdef UART_LOADER_PARITY_EN
      ST_PARITY: tx_d = ^cur_byte;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  // tx and done are registered from the state, so they trail it by one clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      active_q    <= '0;
      act_last_q  <= 1'b0;
      act_sent_q  <= 1'b0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      lock_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
      words_q     <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      lock_q      <= lock_d;
      s_ready_q   <= !hold_full_d && !lock_d;
      tx_q        <= tx_d;
      done_q      <= 1'b0;
      if (accept) begin
        hold_q      <= s_data;
        hold_last_q <= s_last;
      end
      cnt_q <= timer_done ? '0 : cnt_q + CNT_W'(1);

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (hold_full_q) begin
            active_q   <= hold_q;
            act_last_q <= hold_last_q;
            act_sent_q <= 1'b0;
            byte_idx_q <= '0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (timer_done) begin
            bit_idx_q <= '0;
            state_q   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (timer_done) begin
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_LOADER_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_LOADER_PARITY_EN
        ST_PARITY: begin
          if (timer_done) begin
            state_q <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (timer_done) begin
            state_q <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          cnt_q      <= '0;
          byte_idx_q <= byte_idx_q + 2'd1;
          if (!final_byte) begin
            state_q <= ST_START;
          end else begin
            if (!act_sent_q) begin
              words_q <= words_q + 16'd1;
            end
            if (act_sent_q) begin
              done_q <= 1'b1;
            end
            if (act_last_q) begin
              active_q   <= SENTINEL;
              act_last_q <= 1'b0;
              act_sent_q <= 1'b1;
              state_q    <= ST_START;
            end else if (hold_full_q) begin
              active_q   <= hold_q;
              act_last_q <= hold_last_q;
              act_sent_q <= 1'b0;
              state_q    <= ST_START;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign s_ready    = s_ready_q;
  assign tx         = tx_q;
  assign done       = done_q;
  assign words_sent = words_q;
  assign busy       = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_program_loader_tx.sv
// Scoreboard bench: accepted words push expected frames; a UART receiver model on tx pops and compares them,
// and a second monitor checks done timing and the s_ready lockout.
module tb_uart_program_loader_tx;

  localparam int CPB = 4;
`ifdef UART_LOADER_PARITY_EN
  localparam int NSYM = 11;
`else
  localparam int NSYM = 10;
`endif
  localparam int FRAME = NSYM * CPB + 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        tx;
  logic        busy;
  logic        done;
  logic [15:0] words_sent;

  uart_program_loader_tx #(.CLKS_PER_BIT(CPB), .SENTINEL(32'hFFFF_FFFF)) dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .tx(tx), .busy(busy), .done(done), .words_sent(words_sent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { logic [7:0] b; bit contig; bit fin; } exp_t;
  exp_t exp_q[$];
  int   done_q[$];

  task automatic push_word(input logic [31:0] data, input bit last, input bit gapless, input int nbytes);
    exp_t e;
    for (int i = 0; i < nbytes; i++) begin
      e.b = data[8*i +: 8];
      e.contig = (i > 0) || gapless;
      e.fin = 1'b0;
      exp_q.push_back(e);
    end
    if (last && nbytes == 4) begin
      for (int i = 0; i < 4; i++) begin
        e.b = 8'hFF;
        e.contig = 1'b1;
        e.fin = (i == 3);
        exp_q.push_back(e);
      end
    end
  endtask

  // Called and returns on a negedge; acc_cyc is the cycle count seen just after the accepting edge.
  task automatic send_word(input logic [31:0] data, input bit last, input bit gapless,
                           input int nbytes, input bit keep, output int acc_cyc);
    bit ok = 1'b0;
    acc_cyc = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    for (int t = 0; t < 2000 && !ok; t++) begin
      if (s_ready === 1'b1) begin
        @(posedge clk);
        push_word(data, last, gapless, nbytes);
        ok = 1'b1;
        @(negedge clk);
        acc_cyc = cyc;
      end else begin
        @(negedge clk);
      end
    end
    chk("accept", {31'd0, ok}, 1);
    if (!keep) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  // UART receiver model: samples every negedge, checks each bit holds for CPB clks.
  bit         rx_on = 1'b0;
  int         rx_cnt, rx_k, rx_p, rx_start, rx_bad;
  int         prev_start = -1000000;
  logic [7:0] rx_byte;
  logic       rx_stop, rx_ref;
  exp_t       rx_e;
`ifdef UART_LOADER_PARITY_EN
  logic       rx_par;
  logic       rx_par_log[$];
`endif

  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      rx_on = 1'b0;
      prev_start = -1000000;
    end else begin
      if (!rx_on && tx === 1'b0) begin
        rx_on = 1'b1;
        rx_cnt = 0;
        rx_start = cyc;
        rx_bad = 0;
      end
      if (rx_on) begin
        rx_k = rx_cnt / CPB;
        rx_p = rx_cnt % CPB;
        if (rx_p == 0) begin
          rx_ref = tx;
          if (rx_k >= 1 && rx_k <= 8) rx_byte[rx_k-1] = tx;
`ifdef UART_LOADER_PARITY_EN
          else if (rx_k == 9) rx_par = tx;
`endif
          else if (rx_k == NSYM - 1) rx_stop = tx;
        end else if (tx !== rx_ref) begin
          rx_bad++;
        end
        rx_cnt++;
        if (rx_cnt == NSYM * CPB) begin
          rx_on = 1'b0;
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame: got byte %0h, expected no frame (cycle %0d)", rx_byte, cyc);
          end else begin
            rx_e = exp_q.pop_front();
            chk("rx_byte", {24'd0, rx_byte}, {24'd0, rx_e.b});
            chk("rx_stop_bit", {31'd0, rx_stop}, 1);
            chk("rx_bit_width", rx_bad, 0);
`ifdef UART_LOADER_PARITY_EN
            chk("rx_parity", {31'd0, rx_par}, {31'd0, ^rx_e.b});
            rx_par_log.push_back(rx_par);
`endif
            if (rx_e.contig) chk("rx_frame_spacing", rx_start - prev_start, FRAME);
            // done occupies the final clk of the sentinel's last frame period
            if (rx_e.fin) done_q.push_back(rx_start + NSYM * CPB);
          end
          prev_start = rx_start;
        end
      end
    end
  end

  bit in_lock = 1'b0;
  bit chk_rdy_next = 1'b0;
  int lock_viol = 0;
  int done_cnt = 0;
  int done_cyc = 0;

  always @(negedge clk) begin
    if (chk_rdy_next) begin
      chk_rdy_next = 1'b0;
      chk("ready_after_done", {31'd0, s_ready}, 1);
    end
    if (reset_n === 1'b1 && in_lock && s_ready !== 1'b0) lock_viol++;
    if (reset_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      in_lock = 1'b0;
      chk_rdy_next = 1'b1;
      if (done_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL done_spurious: got done=1, expected 0 (cycle %0d)", cyc);
      end else begin
        chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    in_lock = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_s_ready", {31'd0, s_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_words_sent", {16'd0, words_sent}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("s_ready_1clk_after_release", {31'd0, s_ready}, 1);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk(name, {31'd0, t < 3000}, 1);
    repeat (60) @(negedge clk);
  endtask

  initial begin
    int acc, acc2, s0, t;
    reset_n = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;

    // One word with last: 13,05,00,00 then sentinel FF x4
    do_reset();
    send_word(32'h0000_0513, 1'b1, 1'b0, 4, 1'b0, acc);
    t = 0;
    while (tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    s0 = cyc;
    chk("first_start_latency", s0 - acc, 2);
    t = 0;
    while (done !== 1'b1 && t < 1000) begin @(negedge clk); t++; end
    chk("done_after_8_frames", cyc - s0, 8 * FRAME - 1);
    wait_idle("drain_one_word");
    chk("words_one", {16'd0, words_sent}, 1);
    chk("done_count_one", done_cnt, 1);

    // Back-to-back words, gapless framing
    do_reset();
    send_word(32'h1122_3344, 1'b0, 1'b0, 4, 1'b1, acc);
    send_word(32'h5566_7788, 1'b0, 1'b1, 4, 1'b1, acc);
    send_word(32'hDEAD_BEEF, 1'b1, 1'b1, 4, 1'b0, acc);
    wait_idle("drain_b2b");
    chk("words_b2b", {16'd0, words_sent}, 3);

    // Backpressure with s_valid held; includes a sentinel-valued program word
    do_reset();
    lock_viol = 0;
    send_word(32'h0102_0304, 1'b0, 1'b0, 4, 1'b1, acc);
    send_word(32'hA5A5_5A5A, 1'b0, 1'b1, 4, 1'b1, acc);
    chk("bp_ready_low_hold_full", {31'd0, s_ready}, 0);
    send_word(32'hFFFF_FFFF, 1'b0, 1'b1, 4, 1'b1, acc);
    send_word(32'h8040_2010, 1'b0, 1'b1, 4, 1'b1, acc);
    send_word(32'h0F1E_2D3C, 1'b1, 1'b1, 4, 1'b1, acc);
    in_lock = 1'b1;
    send_word(32'h7777_0001, 1'b1, 1'b0, 4, 1'b0, acc2);
    chk("resume_accept_after_done", acc2 - done_cyc, 2);
    in_lock = 1'b1;
    wait_idle("drain_bp");
    chk("lock_violations", lock_viol, 0);
    chk("words_bp", {16'd0, words_sent}, 6);

    // Reset during DATA of byte 2; only bytes D4, C3 ever complete
    do_reset();
    send_word(32'hA1B2_C3D4, 1'b1, 1'b0, 2, 1'b0, acc);
    t = 0;
    while (tx !== 1'b0 && t < 100) begin @(negedge clk); t++; end
    s0 = cyc;
    while (cyc < s0 + 2 * FRAME + CPB + 1) @(negedge clk);
    chk("pre_reset_tx_low", {31'd0, tx}, 0);
    chk("bytes01_received", exp_q.size(), 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_tx", {31'd0, tx}, 1);
    chk("async_reset_busy", {31'd0, busy}, 0);
    chk("async_reset_s_ready", {31'd0, s_ready}, 0);
    do_reset();
    send_word(32'h0000_0097, 1'b1, 1'b0, 4, 1'b0, acc);
    wait_idle("drain_after_reset");
    chk("words_after_reset", {16'd0, words_sent}, 1);

`ifdef UART_LOADER_PARITY_EN
    do_reset();
    rx_par_log.delete();
    send_word(32'h0303_0707, 1'b1, 1'b0, 4, 1'b0, acc);
    wait_idle("drain_parity");
    chk("parity_log_len", rx_par_log.size(), 8);
    if (rx_par_log.size() >= 3) begin
      chk("parity_07", {31'd0, rx_par_log[0]}, 1);
      chk("parity_03", {31'd0, rx_par_log[2]}, 0);
    end
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
